// File: rtl/xtor_stream_core.sv
// Stream transactor core: adds a constant to each accepted word (wrapping or
// saturating) and buffers results in a DEPTH-entry FIFO with flush and counters.
module xtor_stream_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] ADD = DATA_WIDTH'(1),
  parameter bit SATURATE            = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  xfer_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [AW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         count_nxt;
  logic [31:0]           xfer_nxt;
  logic                  i_ready_nxt, o_valid_nxt;
  logic [DATA_WIDTH-1:0] o_data_nxt, f_data;
  logic [DATA_WIDTH:0]   sum;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Carry out of the widened sum selects the clamp in saturating mode
  assign sum    = {1'b0, i_data} + {1'b0, ADD};
  assign f_data = (SATURATE && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    xfer_nxt   = xfer_count;
    push       = 1'b0;
    pop        = 1'b0;
    o_data_nxt = '0;

    case (state)
      INIT: state_nxt = RUN;
      RUN: begin
        if (flush) begin
          state_nxt  = FLUSH;
          wr_ptr_nxt = '0;
          rd_ptr_nxt = '0;
          count_nxt  = '0;
        end else begin
          push = i_valid && i_ready;
          pop  = o_valid && o_ready;
        end
      end
      FLUSH: if (!flush) state_nxt = RUN;
      default: state_nxt = INIT;
    endcase

    if (push) wr_ptr_nxt = wr_ptr + AW'(1);
    if (pop) begin
      rd_ptr_nxt = rd_ptr + AW'(1);
      if (xfer_count != '1) xfer_nxt = xfer_count + 32'd1;
    end
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: ;
    endcase

    i_ready_nxt = (state_nxt == RUN) && (count_nxt < CW'(DEPTH));
    o_valid_nxt = (state_nxt == RUN) && (count_nxt != '0);
    // A word written this edge into an empty FIFO becomes the head, so bypass the array
    if (o_valid_nxt)
      o_data_nxt = (push && (rd_ptr_nxt == wr_ptr)) ? f_data : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      xfer_count <= '0;
      i_ready    <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      xfer_count <= xfer_nxt;
      i_ready    <= i_ready_nxt;
      o_valid    <= o_valid_nxt;
      o_data     <= o_data_nxt;
    end
  end

  // Storage array carries no reset; only entries behind valid pointers are read
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= f_data;
  end

endmodule

// File: tb/tb_xtor_stream_core.sv
// Scoreboard bench for xtor_stream_core: default 32-bit instance plus two 8-bit
// instances (wrap and saturate) for the arithmetic bounds.
module tb_xtor_stream_core;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        i_valid, i_ready, o_valid, o_ready;
  logic [31:0] i_data, o_data, xfer_count;
  logic [2:0]  count;

  logic        i_valid8, o_ready8;
  logic [7:0]  i_data8;
  logic        i_ready_w8, o_valid_w8, i_ready_s8, o_valid_s8;
  logic [7:0]  o_data_w8, o_data_s8;
  logic [2:0]  count_w8, count_s8;
  logic [31:0] xfer_w8, xfer_s8;

  int          n_checks;
  int          n_pass;
  int          exp_xfer;
  logic [31:0] sb_q[$];

  logic [7:0]  a_in [3] = '{8'hFE, 8'hFA, 8'h10};
  logic [7:0]  a_wrp[3] = '{8'h03, 8'hFF, 8'h15};
  logic [7:0]  a_sat[3] = '{8'hFF, 8'hFF, 8'h15};

  xtor_stream_core dut (
    .clock(clock), .reset(reset), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .count(count), .xfer_count(xfer_count)
  );

  xtor_stream_core #(.DATA_WIDTH(8), .DEPTH(4), .ADD(8'd5), .SATURATE(1'b0)) dut_w8 (
    .clock(clock), .reset(reset), .flush(flush),
    .i_valid(i_valid8), .i_ready(i_ready_w8), .i_data(i_data8),
    .o_valid(o_valid_w8), .o_ready(o_ready8), .o_data(o_data_w8),
    .count(count_w8), .xfer_count(xfer_w8)
  );

  xtor_stream_core #(.DATA_WIDTH(8), .DEPTH(4), .ADD(8'd5), .SATURATE(1'b1)) dut_s8 (
    .clock(clock), .reset(reset), .flush(flush),
    .i_valid(i_valid8), .i_ready(i_ready_s8), .i_data(i_data8),
    .o_valid(o_valid_s8), .o_ready(o_ready8), .o_data(o_data_s8),
    .count(count_s8), .xfer_count(xfer_s8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One clock cycle, entered and left at a falling edge; handshakes sampled just before the rising edge
  task automatic step();
    logic        hs_in, hs_out, fl;
    logic [31:0] d_in, d_out;
    #4;
    fl     = flush;
    hs_in  = i_valid && i_ready && !flush;
    hs_out = o_valid && o_ready && !flush;
    d_in   = i_data;
    d_out  = o_data;
    @(posedge clock);
    if (fl) sb_q.delete();
    if (hs_out) begin
      if (exp_xfer != -1) exp_xfer++;
      if (sb_q.size() == 0) check("pop_with_empty_model", 32'(sb_q.size()), 1);
      else check("o_data", d_out, sb_q.pop_front());
    end
    if (hs_in) sb_q.push_back(d_in + 32'd1);
    @(negedge clock);
    check("count", 32'(count), 32'(sb_q.size()));
    check("xfer_count", xfer_count, exp_xfer);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    o_ready = 1'b1;
    while (o_valid && n < 16) begin
      step();
      n++;
    end
    check({tag, "_drained_o_valid"}, 32'(o_valid), 0);
    check({tag, "_drained_o_data"}, o_data, 0);
    check({tag, "_model_empty"}, 32'(sb_q.size()), 0);
  endtask

  initial begin
    int xfer_before;
    n_checks = 0;
    n_pass   = 0;
    exp_xfer = 0;
    reset    = 1'b0;
    flush    = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    o_ready  = 1'b0;
    i_valid8 = 1'b0;
    i_data8  = '0;
    o_ready8 = 1'b0;

    // Reset held for two cycles
    repeat (2) begin
      @(negedge clock);
      check("rst_i_ready", 32'(i_ready), 0);
      check("rst_o_valid", 32'(o_valid), 0);
      check("rst_o_data", o_data, 0);
      check("rst_count", 32'(count), 0);
    end
    reset = 1'b1;
    #1;
    check("init_i_ready", 32'(i_ready), 0);
    check("init_o_valid", 32'(o_valid), 0);
    check("init_count", 32'(count), 0);
    @(negedge clock);
    check("run_i_ready", 32'(i_ready), 1);
    check("run_o_valid", 32'(o_valid), 0);

    // Basic transform
    i_valid = 1'b1;
    i_data  = 32'h1234_5678;
    o_ready = 1'b1;
    step();
    i_valid = 1'b0;
    check("basic_o_valid", 32'(o_valid), 1);
    check("basic_o_data", o_data, 32'h1234_5679);
    step();
    check("basic_xfer", xfer_count, 1);
    check("basic_empty_o_data", o_data, 0);

    // Fill to DEPTH under backpressure; fifth word refused
    o_ready = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_data = 32'h10 + 32'(i);
      step();
    end
    check("full_count", 32'(count), 4);
    check("full_i_ready", 32'(i_ready), 0);
    check("full_head", o_data, 32'h11);
    i_valid = 1'b0;
    drain("fill");

    // Simultaneous push/pop at count=2, pointers wrap
    o_ready = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      i_data = 32'h20 + 32'(i);
      step();
    end
    o_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_data = 32'h30 + 32'(i);
      step();
      check("simul_count", 32'(count), 2);
    end
    i_valid = 1'b0;
    drain("simul");

    // Arithmetic bounds on 8-bit instances, ADD=5
    o_ready8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_valid8 = 1'b1;
      i_data8  = a_in[k];
      step();
      i_valid8 = 1'b0;
      check("arith_wrap_valid", 32'(o_valid_w8), 1);
      check("arith_wrap_data", 32'(o_data_w8), 32'(a_wrp[k]));
      check("arith_sat_valid", 32'(o_valid_s8), 1);
      check("arith_sat_data", 32'(o_data_s8), 32'(a_sat[k]));
      step();
    end
    check("arith_wrap_xfer", xfer_w8, 3);
    check("arith_sat_xfer", xfer_s8, 3);

    // Flush with count=3 while a push is offered
    o_ready = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_data = 32'h40 + 32'(i);
      step();
    end
    check("preflush_count", 32'(count), 3);
    xfer_before = exp_xfer;
    flush  = 1'b1;
    i_data = 32'h50;
    step();
    flush   = 1'b0;
    i_valid = 1'b0;
    check("flush_i_ready", 32'(i_ready), 0);
    check("flush_o_valid", 32'(o_valid), 0);
    check("flush_count", 32'(count), 0);
    check("flush_xfer", xfer_count, 32'(xfer_before));
    step();
    check("postflush_i_ready", 32'(i_ready), 1);
    check("postflush_o_valid", 32'(o_valid), 0);

    // Asynchronous reset mid-operation
    i_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      i_data = 32'h60 + 32'(i);
      step();
    end
    i_valid = 1'b0;
    check("prereset_o_valid", 32'(o_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_o_valid", 32'(o_valid), 0);
    check("async_count", 32'(count), 0);
    check("async_xfer", xfer_count, 0);
    check("async_i_ready", 32'(i_ready), 0);
    sb_q.delete();
    exp_xfer = 0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rerun_i_ready", 32'(i_ready), 1);
    check("rerun_count", 32'(count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
